simon_playback_ctrl: RTL and testbench
======================================

# simon_playback_ctrl

Playback sequencer for the Simon game: on request, it replays the first `len` steps of the pseudo-random colour sequence on the four LEDs. Each step shows a lit LED for a fixed number of ticks, then a dark gap. The main game state machine starts it during Simon's turn and waits for `done`. The block owns the sequence LFSR and its seed register, so every replay regenerates the same colours from the same seed.

## Interface
- `LEN_W`, 5: width of `len` and `stepIdx`.
- `ON_TICKS`, 4: ticks each LED stays lit; must be ≥1.
- `OFF_TICKS`, 2: dark ticks after each step; must be ≥1.
- `SEED_RST`, 16'hACE1: reset value of the seed register and the LFSR.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin playback; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`.
- `len`  in  LEN_W  number of steps to play; latched in LOAD.
- `tick`  in  1  single-cycle timebase enable from the prescaler.
- `seedIn`  in  16  new seed value.
- `seedLoad`  in  1  write `seedIn` into the seed register.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `ledOn`  out  4  one-hot LED drive; 0 when dark.
- `stepIdx`  out  LEN_W  index of the step currently being played, 0-based.

## Operation
- **States:** IDLE, LOAD, ON, OFF, DONE. All state and output registers are synchronous.
- **IDLE:** waits for start.
  - `start && !abort` moves to LOAD.
  - If `abort` is high in the same cycle as `start`, abort wins and the block stays in IDLE.
- **LOAD** (exactly 1 cycle):
  - `lfsr <= seedReg`, `lenReg <= len`, `stepIdx <= 0`, `tickCnt <= 0`.
  - Next state is DONE if `len == 0`, otherwise ON.
- **ON:**
  - `ledOn = 1 << lfsr[1:0]`.
  - On each `tick`, `tickCnt` increments.
  - On `tick && tickCnt == ON_TICKS-1`: `tickCnt <= 0` and move to OFF.
- **OFF:**
  - `ledOn = 0`.
  - On `tick && tickCnt == OFF_TICKS-1`, with `tickCnt <= 0`:
    - if `stepIdx == lenReg-1`, move to DONE;
    - otherwise `stepIdx++`, advance the LFSR, and move to ON.
- **DONE:** `done = 1` for one cycle, then move to IDLE. `stepIdx` holds its last value.
- **LFSR:** 16-bit Galois, right-shift.
  - `next = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000)`.
  - Advances only at the OFF→ON transition.
- **Seed register:** `seedLoad` writes it in any state; the new seed takes effect at the next LOAD.
  - `seedIn == 0` is stored as `16'h0001` so the LFSR never locks up.
- **Abort:**
  - In LOAD, ON, OFF or DONE, `abort` forces IDLE next cycle: `ledOn = 0`, no `done` pulse, `stepIdx` reset to 0.
  - `abort` in IDLE without `start` has no effect.
- **Ignored inputs:** `start` outside IDLE; `len` changes after LOAD.
- **`tick` in LOAD or DONE:** ignored; it does not pre-count.

## Timing
- **Reset values:** state IDLE, `busy = 0`, `done = 0`, `ledOn = 0`, `stepIdx = 0`, `tickCnt = 0`, `seedReg = lfsr = SEED_RST`, `lenReg = 0`.
- **Output decode:** `ledOn`, `busy` and `done` are decoded from registered state, so they are valid in the cycle the state is entered.
- **Start latency:** LOAD is entered 1 cycle after `start` is sampled; the first LED lights 2 cycles after `start`.
- **Duration with `tick` held high:** `len` steps take 1 (LOAD) + `len*(ON_TICKS+OFF_TICKS)` + 1 (DONE) cycles from entering LOAD.
- **`len == 0`:** LOAD → DONE → IDLE, with `busy` high for 2 cycles and no LED lit.
- **`len == 2**LEN_W - 1`:** plays all 31 steps; `stepIdx` never wraps.
- **Back-to-back runs:** `start` is accepted in the cycle after DONE, when the block is back in IDLE.
- **Sparse `tick`:** the state machine holds state between ticks; only tick-qualified cycles count.

## Test plan
- **Single step:** reset, `tick = 1`, `len = 1`, pulse `start` at cycle 0.
  - Required: LOAD at cycle 1; `ledOn = 4'b0010` for cycles 2–5; dark for cycles 6–7; `done` at cycle 8; `busy` 0 at cycle 9.
- **Sequence content:** `len = 3`, default seed.
  - Required: `ledOn` sequence 4'b0010, 4'b0001, 4'b0001 (LFSR values ACE1, E270, 7138), with `stepIdx` 0, 1, 2.
  - A second `start` with no new seed reproduces the identical sequence.
- **Seed handling:**
  - `seedLoad` with `seedIn = 16'h0000`, then `len = 1` → `ledOn = 4'b0010` (seed stored as 0001).
  - `seedLoad` with `seedIn = 16'h0003` → `ledOn = 4'b1000`.
- **Abort and start conflicts:**
  - `abort` during the second ON step → IDLE next cycle, `ledOn = 0`, no `done`, `stepIdx = 0`.
  - `start && abort` in IDLE → remains IDLE.
- **Slow tick and length edges:** `tick` pulsed every 3rd cycle, `len = 1` → ON lasts 12 cycles and OFF 6 cycles.
  - `len = 0` → `done` two cycles after `start` with `ledOn` always 0.
- **Ignored inputs:** `start` pulsed mid-playback and `len` changed after LOAD → the current run is unaffected and the step count matches the latched `len`.

Source files
------------

// File: rtl/simon_playback_ctrl.sv
// simon_playback_ctrl: replays the first `len` colours of the Simon sequence
// on four one-hot LEDs. Each step is ON_TICKS lit ticks followed by OFF_TICKS
// dark ticks. The block owns the seed register and the LFSR, so every replay
// regenerates the same colours until a new seed is loaded.
//
// Handshake: `start` is a level sampled only in IDLE; the run is acknowledged
// by `busy` rising in the next cycle, and completion is a single-cycle `done`
// pulse. `abort` cancels any non-IDLE state without producing `done`.
module simon_playback_ctrl #(
  parameter int          LEN_W     = 5,
  parameter int          ON_TICKS  = 4,
  parameter int          OFF_TICKS = 2,
  parameter logic [15:0] SEED_RST  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic             tick,
  input  logic [15:0]      seedIn,
  input  logic             seedLoad,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ledOn,
  output logic [LEN_W-1:0] stepIdx
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      seedReg;
  logic [15:0]      lfsr;
  logic [15:0]      lfsrNext;
  logic [LEN_W-1:0] lenReg;
  logic [CNT_W-1:0] tickCnt;

  // Galois right-shift step; taps 0xB400 give a maximal-length sequence.
  assign lfsrNext = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Seed register: a zero seed is remapped to 1 so the LFSR can never lock up.
  always_ff @(posedge clk) begin
    if (rst) begin
      seedReg <= SEED_RST;
    end else if (seedLoad) begin
      seedReg <= (seedIn == 16'h0000) ? 16'h0001 : seedIn;
    end
  end

  // Playback FSM; outputs are registered alongside the state so they are
  // valid in the same cycle the corresponding state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ledOn   <= 4'b0000;
      stepIdx <= '0;
      tickCnt <= '0;
      lfsr    <= SEED_RST;
      lenReg  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        ledOn   <= 4'b0000;
        stepIdx <= '0;
        tickCnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            lfsr    <= seedReg;
            lenReg  <= len;
            stepIdx <= '0;
            tickCnt <= '0;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ON;
              ledOn <= 4'b0001 << seedReg[1:0];
            end
          end
          S_ON: begin
            if (tick) begin
              if (tickCnt == ON_LAST) begin
                tickCnt <= '0;
                state   <= S_OFF;
                ledOn   <= 4'b0000;
              end else begin
                tickCnt <= tickCnt + CNT_W'(1);
              end
            end
          end
          S_OFF: begin
            if (tick) begin
              if (tickCnt == OFF_LAST) begin
                tickCnt <= '0;
                if (stepIdx == lenReg - LEN_W'(1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  stepIdx <= stepIdx + LEN_W'(1);
                  lfsr    <= lfsrNext;
                  ledOn   <= 4'b0001 << lfsrNext[1:0];
                  state   <= S_ON;
                end
              end else begin
                tickCnt <= tickCnt + CNT_W'(1);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ledOn <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Bench for simon_playback_ctrl: a reference LFSR model pushes the expected
// {stepIdx, ledOn} of every step into a queue, a monitor pops and compares
// at each LED turn-on, and per-run traces are checked against cycle timings.
module tb_simon_playback_ctrl;

  localparam int LEN_W  = 5;
  localparam int W      = LEN_W + 4;
  localparam int BUDGET = 400;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, abort, tick, seedLoad;
  logic [LEN_W-1:0] len;
  logic [15:0]      seedIn;
  logic             busy, done;
  logic [3:0]       ledOn;
  logic [LEN_W-1:0] stepIdx;

  simon_playback_ctrl #(
    .LEN_W(LEN_W), .ON_TICKS(4), .OFF_TICKS(2), .SEED_RST(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .tick(tick), .seedIn(seedIn), .seedLoad(seedLoad), .busy(busy),
    .done(done), .ledOn(ledOn), .stepIdx(stepIdx)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  cur_seed;

  // per-run traces indexed by cycle number (cycle 0 = start sampled)
  logic [3:0]       tr_led [0:BUDGET];
  logic             tr_busy[0:BUDGET];
  logic [LEN_W-1:0] tr_step[0:BUDGET];
  int done_at, idle_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // push the expected LED/step sequence for n steps from a seed
  task automatic push_expect(input logic [15:0] seed, input int n);
    logic [15:0] l;
    logic [3:0]  oh;
    l = seed;
    for (int i = 0; i < n; i++) begin
      oh = 4'b0001 << l[1:0];
      exp_q.push_back({LEN_W'(i), oh});
      l = model_next(l);
    end
  endtask

  task automatic load_seed(input logic [15:0] v);
    @(negedge clk);
    seedIn   = v;
    seedLoad = 1'b1;
    @(negedge clk);
    seedLoad = 1'b0;
    cur_seed = (v == 16'h0000) ? 16'h0001 : v;
  endtask

  // drive one run; tick_mode 1 = tick held high, 3 = tick in cycles k%3==1
  task automatic run_play(input logic [LEN_W-1:0] l, input int tick_mode,
                          input bit chained, input int abort_at, input int poke_at);
    done_at = 0;
    idle_at = 0;
    if (!chained) @(negedge clk);
    len   = l;
    start = 1'b1;
    abort = 1'b0;
    tick  = (tick_mode == 1);
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      tr_led[k]  = ledOn;
      tr_busy[k] = busy;
      tr_step[k] = stepIdx;
      if (done && done_at == 0) done_at = k;
      if (!busy) begin
        idle_at = k;
        start = 1'b0;
        abort = 1'b0;
        tick  = 1'b0;
        break;
      end
      start = (k == poke_at);
      if (k == poke_at) len = ~len;
      abort = (k == abort_at);
      tick  = (tick_mode == 1) ? 1'b1 : ((k % 3) == 1);
    end
    check("run_ends", (idle_at != 0), 1);
  endtask

  // scoreboard monitor: compare each newly lit step against the queue head
  logic [3:0] prev_led;
  always @(negedge clk) begin
    if (rst) begin
      prev_led = 4'b0000;
    end else begin
      if (ledOn != 4'b0000 && prev_led == 4'b0000) begin
        check("onehot", $onehot(ledOn), 1);
        if (exp_q.size() == 0) check("sb_unexpected", {stepIdx, ledOn}, '0);
        else check("sb_step", {stepIdx, ledOn}, exp_q.pop_front());
      end
      prev_led = ledOn;
    end
  end

  int on_cnt, last_lit;

  initial begin
    rst = 1'b1; start = 0; abort = 0; tick = 0; seedLoad = 0;
    seedIn = 16'h0; len = '0; cur_seed = 16'hACE1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_led", ledOn, 0);
    check("rst_step", stepIdx, 0);
    rst = 1'b0;

    // single step timing
    push_expect(cur_seed, 1);
    run_play(5'd1, 1, 0, 0, 0);
    check("s1_load_busy", tr_busy[1], 1);
    check("s1_load_led", tr_led[1], 0);
    check("s1_led_c2", tr_led[2], 4'b0010);
    check("s1_led_c5", tr_led[5], 4'b0010);
    check("s1_dark_c6", tr_led[6], 0);
    check("s1_dark_c7", tr_led[7], 0);
    check("s1_done_at", done_at, 8);
    check("s1_idle_at", idle_at, 9);

    // three-step content, then an immediate identical replay
    push_expect(cur_seed, 3);
    run_play(5'd3, 1, 0, 0, 0);
    check("s3_done_at", done_at, 20);
    check("s3_last_step", tr_step[20], 2);
    push_expect(cur_seed, 3);
    run_play(5'd3, 1, 1, 0, 0);
    check("b2b_done_at", done_at, 20);

    // zero seed is stored as 1
    load_seed(16'h0000);
    push_expect(cur_seed, 1);
    run_play(5'd1, 1, 0, 0, 0);
    check("seed0_led", tr_led[2], 4'b0010);
    load_seed(16'h0003);
    push_expect(cur_seed, 1);
    run_play(5'd1, 1, 0, 0, 0);
    check("seed3_led", tr_led[2], 4'b1000);
    load_seed(16'hACE1);

    // abort during second ON step
    push_expect(cur_seed, 2);
    run_play(5'd3, 1, 0, 9, 0);
    check("abort_idle_at", idle_at, 10);
    check("abort_no_done", done_at, 0);
    check("abort_led", tr_led[10], 0);
    check("abort_step", tr_step[10], 0);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    @(negedge clk);
    check("sa_busy2", busy, 0);
    check("sa_led", ledOn, 0);

    // slow tick, one step
    push_expect(cur_seed, 1);
    run_play(5'd1, 3, 0, 0, 0);
    on_cnt = 0;
    last_lit = 0;
    for (int k = 1; k <= idle_at; k++) begin
      if (tr_led[k] != 4'b0000) begin
        on_cnt++;
        last_lit = k;
      end
    end
    check("slow_on_cycles", on_cnt, 12);
    check("slow_off_cycles", done_at - last_lit - 1, 6);
    check("slow_done_at", done_at, 20);

    // zero length
    run_play(5'd0, 1, 0, 0, 0);
    check("len0_busy_c1", tr_busy[1], 1);
    check("len0_done_at", done_at, 2);
    check("len0_idle_at", idle_at, 3);
    check("len0_led", tr_led[1] | tr_led[2], 0);

    // start and len change mid-run are ignored
    push_expect(cur_seed, 2);
    run_play(5'd2, 1, 0, 0, 5);
    check("ign_done_at", done_at, 14);
    check("ign_last_step", tr_step[14], 1);

    // maximum length, no wrap
    push_expect(cur_seed, 31);
    run_play(5'd31, 1, 0, 0, 0);
    check("max_done_at", done_at, 188);
    check("max_last_step", tr_step[188], 30);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
